// File: rtl/core_local_interruptor_if.sv
// Data-bus interface between the core (master) and the core-local
// interruptor (slave).
//   rd_en / wr_en : request strobes, held by the master until ack
//   addr          : byte offset within the block
//   wr_data       : store data
//   rd_data       : load data, valid while ack is high
//   ack           : one-cycle request-complete pulse
interface core_local_interruptor_if #(
    parameter int DATA_SIZE = 32
);
    logic                 rd_en;
    logic                 wr_en;
    logic [15:0]          addr;
    logic [DATA_SIZE-1:0] wr_data;
    logic [DATA_SIZE-1:0] rd_data;
    logic                 ack;

    modport master (
        output rd_en, wr_en, addr, wr_data,
        input  rd_data, ack
    );

    modport slave (
        input  rd_en, wr_en, addr, wr_data,
        output rd_data, ack
    );
endinterface

// File: rtl/core_local_interruptor.sv
// Core-local interruptor: memory-mapped msip/ssip/mtime/mtimecmp registers
// with a free-running prescaled mtime counter.
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-low
//   bus      : slave side of the data bus (rd_en, wr_en, addr, wr_data,
//              rd_data, ack)
//   msip     : machine software-interrupt register (bit 0 only)
//   ssip     : supervisor software-interrupt register (bit 0 only)
//   mtime    : 64-bit timer counter
//   mtimecmp : 64-bit timer compare
//
// Bus FSM
//   state | meaning
//   IDLE  | waiting for rd_en/wr_en; on a request capture rd_data, do write
//   ACK   | ack high for exactly one cycle, rd_data stable
//   HOLD  | wait for the requester to drop rd_en and wr_en
module core_local_interruptor #(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    core_local_interruptor_if.slave  bus,
    output logic [DATA_SIZE-1:0]     msip,
    output logic [DATA_SIZE-1:0]     ssip,
    output logic [63:0]              mtime,
    output logic [63:0]              mtimecmp
);

    localparam bit IS32 = (DATA_SIZE == 32);
    localparam int PW   = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_CYCLES_PER_TICK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 msip_q, msip_d;
    logic                 ssip_q, ssip_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic [DATA_SIZE-1:0] rd_value;

    logic [13:0] word;
    logic        unused_addr_lsb;
    logic        req, start, do_wr, tick;
    logic        sel_msip, sel_ssip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic [63:0] wr64;

    // Word address; byte lanes within a word are not decoded.
    assign word            = bus.addr[15:2];
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign sel_msip    = (word == 14'h0000);
    assign sel_ssip    = (word == 14'h3000);
    assign sel_cmp_lo  = (word == 14'h1000);
    assign sel_cmp_hi  = IS32 && (word == 14'h1001);
    assign sel_time_lo = (word == 14'h2FFE);
    assign sel_time_hi = IS32 && (word == 14'h2FFF);

    assign req   = bus.rd_en | bus.wr_en;
    assign start = (state_q == IDLE) && req;
    assign do_wr = start && bus.wr_en;
    assign wr64  = 64'(bus.wr_data);

    // With a single-cycle tick the prescaler sits at 0 and ticks every cycle.
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        rd_value = '0;
        if (sel_msip)
            rd_value = {{(DATA_SIZE-1){1'b0}}, msip_q};
        else if (sel_ssip)
            rd_value = {{(DATA_SIZE-1){1'b0}}, ssip_q};
        else if (sel_cmp_lo)
            rd_value = mtimecmp_q[DATA_SIZE-1:0];
        else if (sel_cmp_hi)
            rd_value = DATA_SIZE'(mtimecmp_q[63:32]);
        else if (sel_time_lo)
            rd_value = mtime_q[DATA_SIZE-1:0];
        else if (sel_time_hi)
            rd_value = DATA_SIZE'(mtime_q[63:32]);
    end

    always_comb begin
        presc_d    = tick ? '0 : presc_q + PW'(1);
        msip_d     = msip_q;
        ssip_d     = ssip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;

        if (do_wr) begin
            if (sel_msip)
                msip_d = bus.wr_data[0];
            if (sel_ssip)
                ssip_d = bus.wr_data[0];
            if (sel_cmp_lo)
                mtimecmp_d = IS32 ? {mtimecmp_q[63:32], wr64[31:0]} : wr64;
            if (sel_cmp_hi)
                mtimecmp_d = {wr64[31:0], mtimecmp_q[31:0]};
            // A bus write to mtime replaces the tick; the untouched half
            // keeps its current value, so no carry crosses halves.
            if (sel_time_lo)
                mtime_d = IS32 ? {mtime_q[63:32], wr64[31:0]} : wr64;
            if (sel_time_hi)
                mtime_d = {wr64[31:0], mtime_q[31:0]};
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = ACK;
                    rd_data_d = rd_value;
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!req) begin
                    state_d   = IDLE;
                    rd_data_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                rd_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            msip_q     <= 1'b0;
            ssip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            msip_q     <= msip_d;
            ssip_q     <= ssip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // ack is decoded from the state register so it falls as soon as reset
    // asserts, without waiting for a clock edge.
    assign bus.ack     = (state_q == ACK);
    assign bus.rd_data = rd_data_q;

    assign msip     = {{(DATA_SIZE-1){1'b0}}, msip_q};
    assign ssip     = {{(DATA_SIZE-1){1'b0}}, ssip_q};
    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;

endmodule

// File: doc/core_local_interruptor.md
Name: core_local_interruptor

Overview:
- Memory-mapped timer/software-interrupt responder on the data bus; the target end of the core's machine-timer and software-interrupt inputs.
- Responds to core load/store requests with a one-cycle acknowledge.
- Holds msip, ssip, mtime and mtimecmp, and drives them continuously to the core's interrupt inputs.

Parameters:
- DATA_SIZE, 32, bus data width; legal values 32 or 64.
- CLOCK_CYCLES_PER_TICK, 10, clock cycles per mtime increment; must be at least 1.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_en  input  1  read request; held by requester until ack.
- wr_en  input  1  write request; held by requester until ack.
- addr  input  16  byte offset within block.
- wr_data  input  DATA_SIZE  write data.
- rd_data  output  DATA_SIZE  read data; valid while ack=1.
- ack  output  1  request-complete pulse.
- msip  output  DATA_SIZE  machine software-interrupt register; bit 0 only.
- ssip  output  DATA_SIZE  supervisor software-interrupt register; bit 0 only.
- mtime  output  64  timer counter.
- mtimecmp  output  64  timer compare.

Behaviour:
- Register map, by offset:
  - 0x0000 msip
  - 0xC000 ssip
  - 0x4000 mtimecmp low, or full 64 bits when DATA_SIZE=64
  - 0x4004 mtimecmp high; DATA_SIZE=32 only
  - 0xBFF8 mtime low, or full 64 bits when DATA_SIZE=64
  - 0xBFFC mtime high; DATA_SIZE=32 only
- addr[1:0] is ignored.
- Any other offset, including 0x4004 or 0xBFFC when DATA_SIZE=64, is unmapped: it reads 0, a write is ignored, and it is still acked.
- msip and ssip: bit 0 is writable from wr_data[0]; all other bits read 0.
- Reset values, applied immediately when reset=0:
  - msip=0, ssip=0, mtime=0, mtimecmp=all ones, prescaler=0.
  - ack=0, rd_data=0, FSM=IDLE.
- Prescaler:
  - Counts 0 to CLOCK_CYCLES_PER_TICK-1, then wraps to 0.
  - mtime increments by 1 in the cycle the prescaler wraps.
  - mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - With CLOCK_CYCLES_PER_TICK=1, mtime increments every cycle.
- Bus FSM, states IDLE, ACK, HOLD:
  - IDLE: if rd_en or wr_en, at the clock edge: capture the selected register into rd_data (pre-write value), perform any write, go to ACK.
  - ACK: ack=1 for exactly one cycle, rd_data stable; go to HOLD.
  - HOLD: ack=0; stay until rd_en=0 and wr_en=0, then IDLE. This prevents a held request from being serviced twice.
  - Latency: request seen at edge N, ack high during cycle N+1.
  - rd_en and wr_en both high: performed as a write; rd_data returns the old value.
  - rd_data is cleared to 0 on return to IDLE.
- Write versus tick in the same cycle:
  - A write to any part of mtime wins over the tick; no increment that cycle.
  - A half write (DATA_SIZE=32) replaces only the addressed half; the other half keeps its current value, with no carry applied.
  - The prescaler keeps counting regardless of bus activity.
- mtimecmp is never modified by hardware. Interrupt comparison is done by the consumer, not here.
- Reset asserted mid-transaction: FSM returns to IDLE, ack drops asynchronously, any not-yet-clocked write is lost.
- Outputs msip, ssip, mtime and mtimecmp are registered, with no combinational path from the bus.

Test Plan:
- Reset release, CLOCK_CYCLES_PER_TICK=10:
  - immediately after release: mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, ack=0.
  - after 50 cycles with no bus traffic: mtime=5.
- Write 0xFFFF_FFFF to msip (wr_en held 5 cycles):
  - exactly one ack pulse, one cycle after the request edge.
  - msip=0x1; a read back returns 0x1.
  - no second ack until wr_en drops and is reasserted.
- DATA_SIZE=32 carry boundary:
  - write 0xFFFF_FFFF to 0xBFF8, then 0 to 0xBFFC.
  - after the next tick, mtime=0x0000_0001_0000_0000; reading 0xBFFC returns 0x1.
- Write/tick collision:
  - write 0x1234 to 0xBFF8 in the exact cycle the prescaler wraps.
  - mtime low=0x1234 with no increment; the increment resumes 10 cycles later.
- Unmapped access:
  - read 0x0100 returns rd_data=0 with ack.
  - write 0xAAAA to 0x0100 changes no output.
  - rd_en and wr_en together to 0x4000 with 0x55: rd_data=0xFFFF_FFFF and mtimecmp low becomes 0x55.
- Reset pulled low during ACK state: ack falls without waiting for a clock edge; after release FSM=IDLE, and a new read of 0x0000 completes normally.
